mult_digit_display: RTL and testbench
=====================================

# mult_digit_display

Small 3-bit × 3-bit multiplier whose product is shown one hex digit at a time on a single seven-segment display. Operands are sampled continuously, latched into the multiplier once per display phase, and the display alternates between the product's high and low nibble. A digit-select output marks which nibble is shown. The block sits between board switches and a 7-segment LED with its decimal point.

## Interface
- `MAX_COUNT`, default 1250: terminal value of the phase counter. Each display phase lasts MAX_COUNT+1 clocks, which is 0.5 s at 2500 Hz. Legal range 1..4095.
- `clk` input, 1 bit: clock, rising-edge.
- `reset` input, 1 bit: reset, synchronous, active-high; clock clk.
- `i_factor_a` input, 3 bits: operand A, unsigned 0..7.
- `i_factor_b` input, 3 bits: operand B, unsigned 0..7.
- `o_segments` output, 7 bits: active-high segment drive, bit order {g,f,e,d,c,b,a}.
- `o_lsb_digit` output, 1 bit: 1 when the low nibble is displayed, 0 when the high nibble is displayed.

## Operation
- **Registers**
  - 12-bit phase counter.
  - 4-bit input sample registers A_in and B_in, each `{1'b0, i_factor}`.
  - 4-bit multiplier operands A and B.
  - Phase flag `lsb`.
  - Registered `o_lsb_digit`.
  - 4-bit display digit.
- **Reset** (synchronous): all registers go to 0. Outputs are `o_segments`=0111111 (digit 0) and `o_lsb_digit`=0.
- **Terminal cycle** (counter == MAX_COUNT):
  - counter ← 0.
  - A ← A_in, B ← B_in.
  - `lsb` ← ~`lsb`.
  - Input samples, digit and `o_lsb_digit` hold.
- **Any other cycle**:
  - counter ← counter+1.
  - A_in ← `{0,i_factor_a}`, B_in ← `{0,i_factor_b}`.
  - `o_lsb_digit` ← `lsb`.
  - digit ← `lsb` ? P[3:0] : P[7:4].
- **Product**: P = A×B, combinational, 8 bits unsigned. The maximum is 49 (0x31), so no overflow is possible.
- **Seven-segment decode** of the digit, combinational, values in {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- **Digit sequence** after reset:
  - Phase 0 shows the high nibble with `o_lsb_digit`=0.
  - Each following phase alternates: low nibble with `o_lsb_digit`=1, then high nibble with `o_lsb_digit`=0.
- Operands are captured at every terminal cycle. Within one high/low pair, the two phases therefore come from products captured one phase apart.

## Timing
- Phase length is MAX_COUNT+1 clocks.
- **Display update** happens on the first clock after a terminal cycle (counter 0→1). At that edge the digit and `o_lsb_digit` take the new operands' product and the new phase, so they change together.
- **Input sampling**:
  - Input latency to the multiplier is 1 clock for sampling plus the wait to the next terminal cycle.
  - Inputs present at the edge that ends a terminal cycle are not sampled.
  - The operand pair is the one sampled on the edge that ended counter value MAX_COUNT−1.
- **Reset mid-phase**: takes effect on the next edge. The counter restarts at 0 and the display shows 0, high phase.
- **Counter wrap**: the counter never exceeds MAX_COUNT. It returns to 0 at the terminal cycle; there is no modulo-4096 wrap inside the legal range.

## Test plan
All directed scenarios use MAX_COUNT=4 (5 clocks per phase).
- **Reset values**: assert `reset` for 2 clocks with inputs a=5, b=3 → `o_segments`=0111111, `o_lsb_digit`=0. Both hold through phase 0.
- **Product 15**: hold a=3, b=5 after reset. First update after the first terminal cycle gives `o_lsb_digit`=1 and `o_segments`=1110001 (F). The next phase gives `o_lsb_digit`=0 and 0111111 (0). Check alternation every 5 clocks.
- **Maximum product 49**: hold a=7, b=7 → low phase shows 0000110 (1), high phase shows 1001111 (3).
- **Sampling boundary**:
  - Change the inputs from 7×7 to 2×3 only during the terminal cycle → the display keeps showing 49 for one more phase.
  - Change the inputs one cycle earlier → the next phase shows 0x06, i.e. 1111101 in the low phase.
- **Zero operand**: a=0, b=7 → both phases show 0111111, with `o_lsb_digit` still toggling.
- **Mid-phase reset**: assert `reset` at counter=2 during a low phase of 49 → the next edge gives 0111111 and `o_lsb_digit`=0. After release, the first update occurs 6 clocks later.

Source files
------------

// File: rtl/mult_digit_display.sv
`default_nettype none
// ============================================================================
// Module   : mult_digit_display
// Brief    : 3x3-bit multiplier whose product is shown one hex nibble at a
//            time on a single seven-segment display, alternating high/low.
// Revision : 1.0 - initial release
// ============================================================================
module mult_digit_display #(
    parameter int MAX_COUNT = 1250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_factor_a,
    input  logic [2:0] i_factor_b,
    output logic [6:0] o_segments,
    output logic       o_lsb_digit
);

    localparam logic [11:0] c_max_count = 12'(MAX_COUNT);

    logic [11:0] r_counter;
    logic [3:0]  r_a_in;
    logic [3:0]  r_b_in;
    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic        r_lsb;
    logic        r_lsb_digit;
    logic [3:0]  r_digit;

    logic        w_terminal;
    logic [7:0]  w_product;
    logic [6:0]  w_segments;

    assign w_terminal = (r_counter == c_max_count);
    assign w_product  = {4'b0000, r_a} * {4'b0000, r_b};

    // Operands move to the multiplier only at the terminal cycle; the display
    // picks up the new product on the following edge together with the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter   <= 12'd0;
            r_a_in      <= 4'd0;
            r_b_in      <= 4'd0;
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_lsb       <= 1'b0;
            r_lsb_digit <= 1'b0;
            r_digit     <= 4'd0;
        end else if (w_terminal) begin
            r_counter <= 12'd0;
            r_a       <= r_a_in;
            r_b       <= r_b_in;
            r_lsb     <= ~r_lsb;
        end else begin
            r_counter   <= r_counter + 12'd1;
            r_a_in      <= {1'b0, i_factor_a};
            r_b_in      <= {1'b0, i_factor_b};
            r_lsb_digit <= r_lsb;
            r_digit     <= r_lsb ? w_product[3:0] : w_product[7:4];
        end
    end

    always_comb begin
        w_segments = 7'b0000000;
        case (r_digit)
            4'h0: w_segments = 7'b0111111;
            4'h1: w_segments = 7'b0000110;
            4'h2: w_segments = 7'b1011011;
            4'h3: w_segments = 7'b1001111;
            4'h4: w_segments = 7'b1100110;
            4'h5: w_segments = 7'b1101101;
            4'h6: w_segments = 7'b1111101;
            4'h7: w_segments = 7'b0000111;
            4'h8: w_segments = 7'b1111111;
            4'h9: w_segments = 7'b1101111;
            4'hA: w_segments = 7'b1110111;
            4'hB: w_segments = 7'b1111100;
            4'hC: w_segments = 7'b0111001;
            4'hD: w_segments = 7'b1011110;
            4'hE: w_segments = 7'b1111001;
            4'hF: w_segments = 7'b1110001;
            default: w_segments = 7'b0000000;
        endcase
    end

    assign o_segments  = w_segments;
    assign o_lsb_digit = r_lsb_digit;

endmodule
`default_nettype wire

// File: tb/tb_mult_digit_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_digit_display
// Brief    : Directed bench for mult_digit_display with MAX_COUNT = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_digit_display;

    localparam logic [6:0] c_seg_0 = 7'b0111111;
    localparam logic [6:0] c_seg_1 = 7'b0000110;
    localparam logic [6:0] c_seg_3 = 7'b1001111;
    localparam logic [6:0] c_seg_6 = 7'b1111101;
    localparam logic [6:0] c_seg_f = 7'b1110001;

    logic       clk;
    logic       reset;
    logic [2:0] i_factor_a;
    logic [2:0] i_factor_b;
    logic [6:0] o_segments;
    logic       o_lsb_digit;

    int checks = 0;
    int errors = 0;

    mult_digit_display #(.MAX_COUNT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_factor_a  (i_factor_a),
        .i_factor_b  (i_factor_b),
        .o_segments  (o_segments),
        .o_lsb_digit (o_lsb_digit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] exp_seg, input logic exp_lsb);
        checks++;
        assert (o_segments === exp_seg) else begin
            errors++;
            $error("FAIL %s segments: got %b expected %b", tag, o_segments, exp_seg);
        end
        checks++;
        assert (o_lsb_digit === exp_lsb) else begin
            errors++;
            $error("FAIL %s lsb_digit: got %b expected %b", tag, o_lsb_digit, exp_lsb);
        end
    endtask

    // One full display phase: the five edges starting with the update edge.
    task automatic run_phase(input string tag, input logic [6:0] exp_seg, input logic exp_lsb);
        for (int i = 0; i < 5; i++) begin
            tick();
            check(tag, exp_seg, exp_lsb);
        end
    endtask

    initial begin
        reset      = 1'b1;
        i_factor_a = 3'd5;
        i_factor_b = 3'd3;
        tick();
        check("reset_1", c_seg_0, 1'b0);
        tick();
        check("reset_2", c_seg_0, 1'b0);

        reset      = 1'b0;
        i_factor_a = 3'd3;
        i_factor_b = 3'd5;
        run_phase("phase0", c_seg_0, 1'b0);          // e1..e5
        run_phase("p15_low", c_seg_f, 1'b1);         // e6..e10
        run_phase("p15_high", c_seg_0, 1'b0);        // e11..e15

        i_factor_a = 3'd7;
        i_factor_b = 3'd7;
        run_phase("p15_low_again", c_seg_f, 1'b1);   // e16..e20
        run_phase("p49_high", c_seg_3, 1'b0);        // e21..e25
        run_phase("p49_low", c_seg_1, 1'b1);         // e26..e30
        run_phase("p49_high2", c_seg_3, 1'b0);       // e31..e35

        // Inputs differ only during the terminal cycle: not sampled.
        for (int i = 0; i < 4; i++) begin            // e36..e39
            tick();
            check("p49_low2", c_seg_1, 1'b1);
        end
        i_factor_a = 3'd2;
        i_factor_b = 3'd3;
        tick();                                      // e40 (terminal)
        check("p49_low2_term", c_seg_1, 1'b1);
        i_factor_a = 3'd7;
        i_factor_b = 3'd7;

        // Inputs change one cycle earlier: sampled at e44, captured at e45.
        for (int i = 0; i < 3; i++) begin            // e41..e43
            tick();
            check("hold49_high", c_seg_3, 1'b0);
        end
        i_factor_a = 3'd2;
        i_factor_b = 3'd3;
        tick();                                      // e44
        check("hold49_high_pre", c_seg_3, 1'b0);
        i_factor_a = 3'd7;
        i_factor_b = 3'd7;
        tick();                                      // e45 (terminal)
        check("hold49_high_term", c_seg_3, 1'b0);
        run_phase("p6_low", c_seg_6, 1'b1);          // e46..e50
        run_phase("p49_high3", c_seg_3, 1'b0);       // e51..e55

        i_factor_a = 3'd0;
        i_factor_b = 3'd7;
        run_phase("p49_low3", c_seg_1, 1'b1);        // e56..e60
        run_phase("zero_high", c_seg_0, 1'b0);       // e61..e65
        run_phase("zero_low", c_seg_0, 1'b1);        // e66..e70

        i_factor_a = 3'd7;
        i_factor_b = 3'd7;
        run_phase("zero_high2", c_seg_0, 1'b0);      // e71..e75
        tick();                                      // e76 -> counter 1
        check("pre_rst_low", c_seg_1, 1'b1);
        tick();                                      // e77 -> counter 2
        check("pre_rst_low2", c_seg_1, 1'b1);
        reset = 1'b1;
        tick();
        check("mid_reset", c_seg_0, 1'b0);
        reset = 1'b0;
        run_phase("post_rst_phase0", c_seg_0, 1'b0);
        tick();
        check("post_rst_update", c_seg_1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
